// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared memory/bus port.
// Grants one requester at a time, holds the grant until the slave
// pulses done, and releases it with an error pulse if the watchdog
// expires first. All outputs are registered.
module bus_arbiter #(
  parameter int NR_MASTER = 2,
  parameter int SEL_LEN   = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR_MASTER-1:0] req,
  input  logic                 done,
  output logic [NR_MASTER-1:0] grant,
  output logic [SEL_LEN-1:0]   sel,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [NR_MASTER-1:0] grant_q, grant_d;
  logic [SEL_LEN-1:0]   last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 win_found;
  logic [SEL_LEN-1:0]   win_idx;
  logic [SEL_LEN:0]     scan_sum;
  logic [SEL_LEN-1:0]   scan_idx;

  // Circular priority scan starting one past the last winner; first hit wins.
  // last <= N-1 and offset <= N keep the sum below 2N, so one subtract wraps it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NR_MASTER; i++) begin
      scan_sum = {1'b0, last_q} + (SEL_LEN + 1)'(i);
      if (scan_sum >= (SEL_LEN + 1)'(NR_MASTER)) begin
        scan_sum = scan_sum - (SEL_LEN + 1)'(NR_MASTER);
      end
      scan_idx = scan_sum[SEL_LEN-1:0];
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, hold and watch the slave in BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = NR_MASTER'(1) << win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // done takes precedence over an expiring watchdog in the same cycle
        if (done) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          grant_d = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves master 0 with top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SEL_LEN'(NR_MASTER - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant       = grant_q;
  assign sel         = last_q;
  assign busy        = (state_q == BUSY);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: a 2-master and a 4-master arbiter (both TIMEOUT=4)
// driven from one vector table, plus hand sequences for reset behaviour.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req2;
  logic       done2;
  logic [1:0] grant2;
  logic [0:0] sel2;
  logic       busy2;
  logic       err2;
  logic [3:0] req4;
  logic       done4;
  logic [3:0] grant4;
  logic [1:0] sel4;
  logic       busy4;
  logic       err4;

  bus_arbiter #(.NR_MASTER(2), .SEL_LEN(1), .TIMEOUT(4)) u_arb2 (
    .clk(clk), .rst(rst), .req(req2), .done(done2),
    .grant(grant2), .sel(sel2), .busy(busy2), .timeout_err(err2)
  );

  bus_arbiter #(.NR_MASTER(4), .SEL_LEN(2), .TIMEOUT(4)) u_arb4 (
    .clk(clk), .rst(rst), .req(req4), .done(done4),
    .grant(grant4), .sel(sel4), .busy(busy4), .timeout_err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       u4;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic u4, input logic [3:0] r, input logic d,
                     input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic e);
    vec_t v;
    v.u4 = u4; v.req = r; v.done = d;
    v.grant = g; v.sel = s; v.busy = b; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic u4, input logic [3:0] g,
                       input logic [1:0] s, input logic b, input logic e);
    logic [3:0] ag;
    logic [1:0] as;
    logic       ab, ae;
    if (u4) begin
      ag = grant4; as = sel4; ab = busy4; ae = err4;
    end else begin
      ag = {2'b00, grant2}; as = {1'b0, sel2}; ab = busy2; ae = err2;
    end
    n_vec++;
    if (ag !== g || as !== s || ab !== b || ae !== e) begin
      n_err++;
      $display("FAIL %s: got grant=%b sel=%0d busy=%b err=%b, want grant=%b sel=%0d busy=%b err=%b",
               name, ag, as, ab, ae, g, s, b, e);
    end
  endtask

  initial begin
    rst = 1'b1; req2 = '0; done2 = 1'b0; req4 = '0; done4 = 1'b0;

    // u4 | req | done || grant | sel | busy | err
    // round-robin with both masters requesting
    add(0, 4'b0011, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0011, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0011, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b0011, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0011, 1, 4'b0000, 0, 0, 0);
    // dropped req does not release; done in IDLE is ignored
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0000, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
    // single requester is re-granted every cycle pair
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 1, 4'b0000, 1, 0, 0);
    // watchdog expiry: grant at t, release with error after t+4
    add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // done on the expiry cycle wins, no error
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
    // 4-master wrap-around from last=2
    add(1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(1, 4'b0100, 1, 4'b0000, 2, 0, 0);
    add(1, 4'b1011, 0, 4'b1000, 3, 1, 0);
    add(1, 4'b1011, 1, 4'b0000, 3, 0, 0);
    add(1, 4'b0011, 0, 4'b0001, 0, 1, 0);
    add(1, 4'b0011, 1, 4'b0000, 0, 0, 0);

    // reset values
    #12;
    check("reset2", 0, 4'b0000, 2'd1, 0, 0);
    check("reset4", 1, 4'b0000, 2'd3, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      if (vecs[k].u4) begin
        req4 = vecs[k].req; done4 = vecs[k].done; req2 = '0; done2 = 1'b0;
      end else begin
        req2 = vecs[k].req[1:0]; done2 = vecs[k].done; req4 = '0; done4 = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), vecs[k].u4, vecs[k].grant, vecs[k].sel,
            vecs[k].busy, vecs[k].err);
    end

    // asynchronous reset in the middle of a grant
    @(negedge clk);
    req4 = '0; done4 = 1'b0; req2 = 2'b11; done2 = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_grant", 0, 4'b0001, 2'd0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, 4'b0000, 2'd1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    req2 = 2'b11;
    @(posedge clk);
    #1;
    check("first_grant", 0, 4'b0001, 2'd0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single memory/bus port of the NPC core between up to NR_MASTER requesters (instruction fetch, load/store unit, and later others). It grants exactly one requester at a time, holds the grant until the downstream transaction completes, and drives the select key of the downstream request/response mux. A watchdog releases the grant and flags an error if the slave never signals completion.

## Interface

- NR_MASTER, 2: number of requesters; legal range 2..8.
- SEL_LEN, 1: width of `sel`; must equal ceil(log2(NR_MASTER)).
- TIMEOUT, 255: maximum cycles a grant may stay held waiting for `done`; legal range 1..65535.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NR_MASTER  per-master request level; bit i = master i.
- done  input  1  one-cycle pulse from the slave side; current transaction complete.
- grant  output  NR_MASTER  one-hot grant; all zero when idle.
- sel  output  SEL_LEN  binary index of the granted master; the select key for the downstream mux.
- busy  output  1  high while a grant is held.
- timeout_err  output  1  one-cycle pulse when the watchdog releases a grant.

## Operation

- States: IDLE, BUSY. Reset state IDLE.
- Round-robin pointer `last` (SEL_LEN bits) holds the index of the most recently granted master; reset value NR_MASTER-1, so master 0 has top priority after reset.
- IDLE: if `req` is nonzero, pick the first set bit scanning circularly from index last+1 upward, wrapping modulo NR_MASTER. Register grant, sel and last = winner, then go to BUSY. If `req` is zero, stay in IDLE.
- BUSY: grant and sel stay frozen. The watchdog counter increments every cycle.
  - If `done`=1: clear grant, go to IDLE.
  - Else if the counter reaches TIMEOUT: clear grant, pulse timeout_err for one cycle, go to IDLE.
- `done` and a timeout in the same cycle: `done` wins, and there is no error pulse.
- `done` while in IDLE is ignored.
- Requesters must hold `req` until their `done`. If `req` drops while BUSY, it does not release the grant; only `done` or timeout releases it.
- `sel` holds its last value while IDLE, so the mux key is stable. `grant` is the authoritative validity indicator.
- The watchdog counter is ceil(log2(TIMEOUT+1)) bits wide. It clears on entry to BUSY and never wraps.

## Timing

- Reset values: grant=0, sel=NR_MASTER-1 (truncated to SEL_LEN bits), busy=0, timeout_err=0, state IDLE, counter 0. Reset applies immediately and asynchronously, including mid-transaction. The first grant after reset deassertion goes to master 0 if it is requesting.
- Grant latency: `req` sampled in IDLE at edge t produces grant/busy high after edge t (visible in cycle t+1). All outputs are registered; there is no combinational path from inputs to outputs.
- Release: `done` sampled high at edge t produces grant=0 and busy=0 in cycle t+1.
- Back-to-back: there is at least one IDLE cycle between consecutive grants. With continuous requests, grant is high 1 cycle after `done`→IDLE plus 1 arbitration cycle. Minimum grant period is 2 cycles (grant, then `done` in that cycle).
- Timeout: if the grant is entered at edge t and `done` never comes, release and the timeout_err pulse occur after edge t+TIMEOUT.

## Test plan

- Reset/first grant: assert rst mid-BUSY with grant=01 → grant=00, busy=0 immediately. Then deassert rst and apply req=11 → after one edge grant=01, sel=0.
- Round-robin fairness, NR_MASTER=2: hold req=11 and pulse `done` one cycle after each grant → grant sequence 01, 00, 10, 00, 01, …, with sel alternating 0, 1, 0.
- Wrap-around, NR_MASTER=4: last=2, req=1011 → grant=1000 (sel=3). Next arbitration with req=0011 → grant=0001 (sel=0).
- Hold and ignore: while grant=10, drop req to 00 and pulse `done` in IDLE afterwards → grant stays 10 until the first `done`. The later idle `done` has no effect, and busy stays 0.
- Timeout, TIMEOUT=4: grant at edge t, no `done` → timeout_err=1 for exactly one cycle after edge t+4, with grant=0 that same cycle. Repeat with `done` at edge t+4 → no error pulse.
- Single requester: req=10 continuously, `done` pulsed each grant → master 1 is re-granted every cycle-pair; there is no starvation path to master 0 when it is idle.
